axis_packet_checker: RTL
========================

# axis_packet_checker

AXI4-Stream sink directly downstream of the sample generator. Accepts its packets, applies a programmable tready backpressure pattern, checks that tdata is a gap-free incrementing count across packets and that every packet has the expected beat count, and exposes saturating packet/error counters plus a sticky error flag for bring-up and regression.

## Interface
- DATA_WIDTH, 40: tdata width; expected count is compared over all DATA_WIDTH bits.
- EXPECTED_LEN, 7: required beats per packet (tlast on beat EXPECTED_LEN); legal range 1..65535.
- CNT_WIDTH, 16: width of each statistics counter.

- Clk  input  1  sole clock; all logic on rising edge.
- Reset  input  1  synchronous, active-high reset.
- En  input  1  level enable; 1 = accept traffic, 0 = finish current packet then stop.
- ReadyPattern  input  8  backpressure mask; bit [phase] gives tready for that cycle; 8'hFF = no backpressure.
- S_AXIS_tvalid  input  1  upstream valid.
- S_AXIS_tready  output  1  registered ready.
- S_AXIS_tlast  input  1  last beat of packet.
- S_AXIS_tdata  input  DATA_WIDTH  payload (incrementing count).
- PacketCount  output  CNT_WIDTH  packets completed (tlast accepted), saturating.
- DataErrorCount  output  CNT_WIDTH  beats whose tdata != expected, saturating.
- LenErrorCount  output  CNT_WIDTH  packets with length != EXPECTED_LEN, saturating.
- LastPacketLen  output  16  beat count of most recently completed packet.
- ErrorSticky  output  1  set on any data or length error; cleared only by Reset.
- Busy  output  1  1 in RUN or STOPPING.

## Operation
- Transfer = S_AXIS_tvalid & S_AXIS_tready (same cycle). Nothing is sampled without a transfer.
- FSM states: IDLE, RUN, STOPPING.
  - IDLE: tready forced 0. En=1 -> RUN.
  - RUN: tready per pattern. En=0 with beat counter 0 (packet boundary) -> IDLE; En=0 mid-packet -> STOPPING.
  - STOPPING: tready per pattern; transfer with tlast -> IDLE. En returning to 1 -> RUN (no packet loss).
- Phase: 3-bit counter, increments every cycle in RUN/STOPPING, wraps 7->0, held at 0 in IDLE.
- Ready: S_AXIS_tready register <= (next state != IDLE) & ReadyPattern[next phase]. ReadyPattern sampled every cycle, no latching.
- Data check: ExpectedR (DATA_WIDTH) resets to 0. Each transfer: if tdata != ExpectedR, DataErrorCount++ and ErrorSticky=1. ExpectedR <= tdata + 1 always (resync to received value, so one dropped beat counts one error, not a cascade). Wrap all-ones -> 0 is legal, not an error.
- Length check: BeatCntR (16 bits) counts transfers in current packet. On tlast transfer: len = BeatCntR + 1; LastPacketLen <= len; PacketCount++; if len != EXPECTED_LEN, LenErrorCount++ and ErrorSticky=1; BeatCntR <= 0. Non-tlast transfer at BeatCntR = 65535 saturates (no wrap); packet then flagged as length error at its tlast.
- Same-beat data and length error: both counters increment in that cycle.
- All counters saturate at all-ones; no wrap.

## Timing
- Reset values: S_AXIS_tready 0, all counters 0, LastPacketLen 0, ErrorSticky 0, Busy 0, FSM IDLE, ExpectedR 0, phase 0.
- En rise -> RUN next edge; first possible tready=1 one cycle after that (registered ready). En=1 held from reset release with ReadyPattern=FF: tready=1 from cycle 2.
- Counters, LastPacketLen, ErrorSticky update on the edge ending the transfer cycle (visible 1 cycle after).
- Reset asserted mid-packet: everything returns to reset values next edge; a partial packet is discarded uncounted; tready low while Reset=1.
- tready is not combinationally dependent on tvalid (AXI-compliant); tvalid may assert while tready=0 without effect.

## Test plan
- Reset, En=1, FF pattern, upstream sends 3 packets of 7 beats, data 0..20 -> tready=1 continuous after cycle 2; PacketCount=3, errors 0, LastPacketLen=7, ErrorSticky=0.
- ReadyPattern=8'b0101_0101, same traffic -> tready toggles per phase; no beat lost; final counts as above, transfers take ~2x cycles.
- Data skip: beats 0,1,2,4,5,6,7 (tlast on 7th) -> DataErrorCount=1, LenErrorCount=0, ErrorSticky=1; next packet starting at 8 -> no new error.
- Short packet: tlast on 5th beat -> LenErrorCount=1, LastPacketLen=5, PacketCount=1.
- En dropped after beat 3 of a packet -> STOPPING, remaining 4 beats accepted, IDLE after tlast, tready=0 next cycle, PacketCount incremented; En dropped between packets -> IDLE directly.
- Reset mid-packet after beat 4 -> all outputs 0 next cycle; fresh packet 0..6 then yields PacketCount=1, no errors.

Source files
------------

// File: rtl/axis_packet_checker.sv
// AXI4-Stream sink that applies a programmable tready pattern and checks the
// received tdata for a gap-free incrementing count and a fixed packet length.
module axis_packet_checker #(
  parameter int DATA_WIDTH   = 40,
  parameter int EXPECTED_LEN = 7,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  En,
  input  logic [7:0]            ReadyPattern,
  input  logic                  S_AXIS_tvalid,
  output logic                  S_AXIS_tready,
  input  logic                  S_AXIS_tlast,
  input  logic [DATA_WIDTH-1:0] S_AXIS_tdata,
  output logic [CNT_WIDTH-1:0]  PacketCount,
  output logic [CNT_WIDTH-1:0]  DataErrorCount,
  output logic [CNT_WIDTH-1:0]  LenErrorCount,
  output logic [15:0]           LastPacketLen,
  output logic                  ErrorSticky,
  output logic                  Busy,
  output logic [1:0]            DebugState
);

  // Handshake: a beat moves only in a cycle where S_AXIS_tvalid and the
  // registered S_AXIS_tready are both high; tready never looks at tvalid.

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } state_t;

  localparam logic [16:0]          EXP_LEN = 17'(EXPECTED_LEN);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [15:0]          BEAT_MAX = 16'hFFFF;

  state_t                state, state_next;
  logic [2:0]            phase, phase_next;
  logic [DATA_WIDTH-1:0] expected;
  logic [15:0]           beat_cnt;
  logic [16:0]           pkt_len;
  logic                  xfer, xfer_last, data_err, len_err;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_WIDTH'(1);
  endfunction

  assign xfer      = S_AXIS_tvalid & S_AXIS_tready;
  assign xfer_last = xfer & S_AXIS_tlast;
  assign data_err  = xfer & (S_AXIS_tdata != expected);
  // 17 bits so a saturated 65535-beat packet plus its tlast never matches.
  assign pkt_len   = {1'b0, beat_cnt} + 17'd1;
  assign len_err   = xfer_last & (pkt_len != EXP_LEN);

  assign Busy       = (state != IDLE);
  assign DebugState = state;

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (En) state_next = RUN;
      RUN: begin
        // The boundary decision includes a beat moving in this very cycle.
        if (!En) begin
          if (xfer)                state_next = S_AXIS_tlast ? IDLE : STOPPING;
          else if (beat_cnt == '0) state_next = IDLE;
          else                     state_next = STOPPING;
        end
      end
      STOPPING: begin
        if (En)             state_next = RUN;
        else if (xfer_last) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    phase_next = ((state == IDLE) || (state_next == IDLE)) ? 3'd0 : phase + 3'd1;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state          <= IDLE;
      phase          <= 3'd0;
      S_AXIS_tready  <= 1'b0;
      expected       <= '0;
      beat_cnt       <= '0;
      PacketCount    <= '0;
      DataErrorCount <= '0;
      LenErrorCount  <= '0;
      LastPacketLen  <= '0;
      ErrorSticky    <= 1'b0;
    end else begin
      state         <= state_next;
      phase         <= phase_next;
      S_AXIS_tready <= (state_next != IDLE) & ReadyPattern[phase_next];

      // Resync to the received value so a dropped beat costs one error only.
      if (xfer) expected <= S_AXIS_tdata + DATA_WIDTH'(1);

      if (xfer_last) begin
        beat_cnt      <= '0;
        LastPacketLen <= (beat_cnt == BEAT_MAX) ? BEAT_MAX : pkt_len[15:0];
        PacketCount   <= sat_inc(PacketCount);
      end else if (xfer && (beat_cnt != BEAT_MAX)) begin
        beat_cnt <= beat_cnt + 16'd1;
      end

      if (data_err)            DataErrorCount <= sat_inc(DataErrorCount);
      if (len_err)             LenErrorCount  <= sat_inc(LenErrorCount);
      if (data_err | len_err)  ErrorSticky    <= 1'b1;
    end
  end

endmodule
